// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default pointer width and Gray/binary helpers used
// by both the read-side and write-side pointer handlers.
package fifo_pkg;

    localparam int unsigned PTR_WIDTH_DEF = 3;
    localparam int unsigned CONV_W        = 32;

    function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] gray);
        logic [CONV_W-1:0] bin;
        bin = '0;
        for (int unsigned i = 0; i < CONV_W; i++) begin
            bin[i] = ^(gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Parameterised Gray-to-binary converter: bit i is the XOR of Gray bits i..MSB.
module gray2bin #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    always_comb begin
        bin = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/r_ptr_handler.sv
// Read-side pointer handler for an asynchronous FIFO: binary/Gray read
// pointers, empty/almost-empty flags, read-side occupancy and sticky underflow.
module r_ptr_handler
    import fifo_pkg::*;
#(
    parameter int unsigned PTR_WIDTH = PTR_WIDTH_DEF,
    parameter int unsigned AE_THRESH = 1
) (
    input  logic                 rclk,
    input  logic                 rst,
    input  logic                 r_en,
    input  logic [PTR_WIDTH:0]   g_wptr_sync,
    output logic [PTR_WIDTH:0]   b_rptr,
    output logic [PTR_WIDTH:0]   g_rptr,
    output logic                 rd_ack,
    output logic                 empty,
    output logic                 almost_empty,
    output logic [PTR_WIDTH:0]   rd_count,
    output logic                 underflow
);

    localparam int unsigned PW1 = PTR_WIDTH + 1;
    localparam logic [PTR_WIDTH:0] AE_LIMIT = PW1'(AE_THRESH);

    logic [PTR_WIDTH:0] b_rptr_next;
    logic [PTR_WIDTH:0] g_rptr_next;
    logic [PTR_WIDTH:0] wbin;
    logic [PTR_WIDTH:0] count_next;

    gray2bin #(
        .WIDTH(PW1)
    ) u_wptr_g2b (
        .gray(g_wptr_sync),
        .bin (wbin)
    );

    // Flags and count are computed from the next pointer so they settle on the
    // same edge as the read that empties the FIFO.
    always_comb begin
        rd_ack      = r_en & ~empty;
        b_rptr_next = b_rptr + {{PTR_WIDTH{1'b0}}, rd_ack};
        g_rptr_next = PW1'(bin2gray(CONV_W'(b_rptr_next)));
        count_next  = wbin - b_rptr_next;
    end

    always_ff @(posedge rclk) begin
        if (rst) begin
            b_rptr       <= '0;
            g_rptr       <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rd_count     <= '0;
            underflow    <= 1'b0;
        end else begin
            b_rptr       <= b_rptr_next;
            g_rptr       <= g_rptr_next;
            empty        <= (g_rptr_next == g_wptr_sync);
            almost_empty <= (count_next <= AE_LIMIT);
            rd_count     <= count_next;
            underflow    <= underflow | (r_en & empty);
        end
    end

endmodule

// File: tb/tb_r_ptr_handler.sv
// Directed self-checking bench for r_ptr_handler (PTR_WIDTH=3, AE_THRESH=1).
module tb_r_ptr_handler;

    logic       rclk;
    logic       rst;
    logic       r_en;
    logic [3:0] g_wptr_sync;
    logic [3:0] b_rptr;
    logic [3:0] g_rptr;
    logic       rd_ack;
    logic       empty;
    logic       almost_empty;
    logic [3:0] rd_count;
    logic       underflow;

    int tests_run    = 0;
    int tests_failed = 0;

    r_ptr_handler #(
        .PTR_WIDTH(3),
        .AE_THRESH(1)
    ) dut (
        .rclk        (rclk),
        .rst         (rst),
        .r_en        (r_en),
        .g_wptr_sync (g_wptr_sync),
        .b_rptr      (b_rptr),
        .g_rptr      (g_rptr),
        .rd_ack      (rd_ack),
        .empty       (empty),
        .almost_empty(almost_empty),
        .rd_count    (rd_count),
        .underflow   (underflow)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    // Advance one edge; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; r_en = 1'b0; g_wptr_sync = 4'b0000;
        tick(); tick();
        tests_run++;
        if ({b_rptr, g_rptr, empty, almost_empty, rd_count, underflow} !== {4'd0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset b=%0d g=%b e=%b ae=%b cnt=%0d uf=%b exp b=0 g=0000 e=1 ae=1 cnt=0 uf=0",
                     b_rptr, g_rptr, empty, almost_empty, rd_count, underflow);
        end
        rst = 1'b0;
        r_en = 1'b1;
        #1;
        tests_run++;
        if (rd_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_rd_ack got %b exp 0", rd_ack);
        end
        r_en = 1'b0;
    endtask

    task automatic test_drain();
        logic [3:0] exp_b [3];
        logic [3:0] exp_g [3];
        logic [3:0] exp_c [3];
        logic       exp_ae[3];
        logic       exp_e [3];
        exp_b = '{4'd1, 4'd2, 4'd3};
        exp_g = '{4'b0001, 4'b0011, 4'b0010};
        exp_c = '{4'd2, 4'd1, 4'd0};
        exp_ae = '{1'b0, 1'b1, 1'b1};
        exp_e = '{1'b0, 1'b0, 1'b1};
        g_wptr_sync = 4'b0010;
        tick();
        tests_run++;
        if ({empty, rd_count, almost_empty} !== {1'b0, 4'd3, 1'b0}) begin
            tests_failed++;
            $display("FAIL drain_load e=%b cnt=%0d ae=%b exp e=0 cnt=3 ae=0", empty, rd_count, almost_empty);
        end
        for (int i = 0; i < 3; i++) begin
            r_en = 1'b1;
            #1;
            tests_run++;
            if (rd_ack !== 1'b1) begin
                tests_failed++;
                $display("FAIL drain_ack%0d got %b exp 1", i, rd_ack);
            end
            tick();
            tests_run++;
            if ({b_rptr, g_rptr, rd_count, almost_empty, empty} !== {exp_b[i], exp_g[i], exp_c[i], exp_ae[i], exp_e[i]}) begin
                tests_failed++;
                $display("FAIL drain%0d b=%0d g=%b cnt=%0d ae=%b e=%b exp b=%0d g=%b cnt=%0d ae=%b e=%b",
                         i, b_rptr, g_rptr, rd_count, almost_empty, empty,
                         exp_b[i], exp_g[i], exp_c[i], exp_ae[i], exp_e[i]);
            end
        end
        r_en = 1'b0;
    endtask

    task automatic test_underflow();
        r_en = 1'b1;
        #1;
        tests_run++;
        if (rd_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL uf_ack got %b exp 0", rd_ack);
        end
        tick();
        r_en = 1'b0;
        tests_run++;
        if ({b_rptr, g_rptr, underflow, empty} !== {4'd3, 4'b0010, 1'b1, 1'b1}) begin
            tests_failed++;
            $display("FAIL uf_set b=%0d g=%b uf=%b e=%b exp b=3 g=0010 uf=1 e=1", b_rptr, g_rptr, underflow, empty);
        end
        for (int i = 0; i < 10; i++) tick();
        tests_run++;
        if (underflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL uf_sticky got %b exp 1", underflow);
        end
    endtask

    task automatic test_wrap();
        // Advance read pointer to 15: writer at bin 11, then bin 15.
        g_wptr_sync = 4'b1110;
        tick();
        tests_run++;
        if (rd_count !== 4'd8) begin
            tests_failed++;
            $display("FAIL wrap_cnt8 got %0d exp 8", rd_count);
        end
        r_en = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        r_en = 1'b0;
        g_wptr_sync = 4'b1000;
        tick();
        r_en = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        r_en = 1'b0;
        tests_run++;
        if ({b_rptr, g_rptr, empty} !== {4'd15, 4'b1000, 1'b1}) begin
            tests_failed++;
            $display("FAIL wrap_at15 b=%0d g=%b e=%b exp b=15 g=1000 e=1", b_rptr, g_rptr, empty);
        end
        g_wptr_sync = 4'b0000;
        tick();
        tests_run++;
        if ({empty, rd_count, almost_empty} !== {1'b0, 4'd1, 1'b1}) begin
            tests_failed++;
            $display("FAIL wrap_one e=%b cnt=%0d ae=%b exp e=0 cnt=1 ae=1", empty, rd_count, almost_empty);
        end
        r_en = 1'b1;
        tick();
        r_en = 1'b0;
        tests_run++;
        if ({b_rptr, g_rptr, empty, rd_count} !== {4'd0, 4'b0000, 1'b1, 4'd0}) begin
            tests_failed++;
            $display("FAIL wrap b=%0d g=%b e=%b cnt=%0d exp b=0 g=0000 e=1 cnt=0", b_rptr, g_rptr, empty, rd_count);
        end
    endtask

    task automatic test_full_depth();
        g_wptr_sync = 4'b1100;
        tick();
        tests_run++;
        if ({rd_count, empty, almost_empty} !== {4'd8, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL full cnt=%0d e=%b ae=%b exp cnt=8 e=0 ae=0", rd_count, empty, almost_empty);
        end
    endtask

    task automatic test_concurrent();
        // Read and writer advance (bin 8 -> 9) in the same cycle.
        r_en = 1'b1;
        g_wptr_sync = 4'b1101;
        tick();
        r_en = 1'b0;
        tests_run++;
        if ({b_rptr, g_rptr, rd_count, empty, almost_empty} !== {4'd1, 4'b0001, 4'd8, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL concurrent b=%0d g=%b cnt=%0d e=%b ae=%b exp b=1 g=0001 cnt=8 e=0 ae=0",
                     b_rptr, g_rptr, rd_count, empty, almost_empty);
        end
    endtask

    task automatic test_reset_mid();
        r_en = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        tests_run++;
        if ({b_rptr, rd_count} !== {4'd4, 4'd5}) begin
            tests_failed++;
            $display("FAIL mid_pre b=%0d cnt=%0d exp b=4 cnt=5", b_rptr, rd_count);
        end
        rst = 1'b1;
        tick();
        tests_run++;
        if ({b_rptr, g_rptr, empty, almost_empty, rd_count, underflow} !== {4'd0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL mid_reset b=%0d g=%b e=%b ae=%b cnt=%0d uf=%b exp b=0 g=0000 e=1 ae=1 cnt=0 uf=0",
                     b_rptr, g_rptr, empty, almost_empty, rd_count, underflow);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (rd_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_rd_ack got %b exp 0", rd_ack);
        end
        r_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_drain();
        test_underflow();
        test_wrap();
        test_full_depth();
        test_concurrent();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
